tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: W, default 1, width in bits of one lane sample.
REQ-002 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port: rst, input, 1, asynchronous active-high reset.
REQ-004 Port: din, input, W, time-multiplexed lane sample.
REQ-005 Port: din_valid, input, 1, din carries a sample this cycle.
REQ-006 Port: sync, input, 1, qualified by din_valid; marks the current sample as slot 0 (lane I0).
REQ-007 Port: Out, output, 4*W, demultiplexed frame; lane k at bits [k*W +: W], so Out[k] pairs with Sel=k at the multiplexer end.
REQ-008 Port: out_valid, output, 1, one-cycle pulse when Out has been loaded with a new complete frame.
REQ-009 Port: Sel, output, 2, slot index the next accepted sample will occupy.
REQ-010 Port: locked, output, 1, high while in state LOCK.
REQ-011 Port: frame_err, output, 1, one-cycle pulse on sync arriving mid-frame.

Function
REQ-012 The block SHALL have two states: HUNT and LOCK; it SHALL enter HUNT on reset.
REQ-013 In HUNT, samples with sync=0 SHALL be discarded, with Sel held at 0.
REQ-014 In HUNT, din_valid=1 with sync=1 SHALL store din in lane 0, set Sel=1 and move to LOCK on the same edge.
REQ-015 In LOCK, each din_valid=1 sample SHALL be stored in the shadow lane Sel, and Sel SHALL increment modulo 4 (3 wraps to 0).
REQ-016 Cycles with din_valid=0 SHALL leave all state, shadow lanes, Sel and Out unchanged, and SHALL hold out_valid at 0.
REQ-017 Acceptance of the slot-3 sample SHALL load Out with lanes 0..2 from the shadow register and lane 3 from din, and SHALL pulse out_valid for exactly one cycle; Out and out_valid are registered, so they are visible the cycle after that edge.
REQ-018 Out SHALL hold its value between completed frames; partial frames SHALL never reach Out.
REQ-019 In LOCK, sync=1 with Sel=0 SHALL be treated as a normal slot-0 sample.
REQ-020 In LOCK, sync=0 with Sel=0 SHALL also be accepted as slot 0; sync is not required after lock.
REQ-021 In LOCK, din_valid=1 and sync=1 with Sel!=0 SHALL:
 - pulse frame_err for one cycle;
 - discard the partial frame, with no out_valid;
 - store din as the new slot 0 and set Sel=1;
 - remain in LOCK.
REQ-022 frame_err and out_valid SHALL never assert in the same cycle.
REQ-023 Throughput SHALL be one sample per clock with no back-pressure; back-to-back frames SHALL produce an out_valid every 4 accepted samples.
REQ-024 locked SHALL equal (state==LOCK); Sel SHALL always be a registered value.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force:
 - state=HUNT, Sel=0, locked=0;
 - Out=0, out_valid=0, frame_err=0;
 - shadow lanes=0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; after release the block SHALL require a new sync to lock.
REQ-027 The first rising clk edge with rst=0 SHALL process inputs normally.

Verification
REQ-028 Reset then idle: rst pulse, no valid -> Out=4'b0000, Sel=0, locked=0, out_valid never asserted.
REQ-029 Basic frame (W=1): valid samples 1(sync),0,1,1 on consecutive cycles -> one cycle after the 4th sample, Out=4'b1101 and out_valid=1 for one cycle; locked=1 from the 2nd cycle.
REQ-030 Pre-lock discard: samples 1,1 with sync=0, then 0(sync),0,0,1 -> Out=4'b1000; no out_valid before that.
REQ-031 Gaps and wrap: frame 0(sync),1,1,0 with din_valid=0 gaps of 2 cycles between samples, then frame 1,0,0,0 without sync -> Out=4'b0110 then 4'b0001; Sel sequence 1,2,3,0,1,2,3,0.
REQ-032 Mid-frame resync: after lock, samples 1,1 then 0 with sync=1 (at Sel=2), then 1,1,1 -> frame_err pulse on the resync sample, no out_valid for the aborted frame, then Out=4'b1110.
REQ-033 Async reset mid-frame: rst asserted between clock edges after 2 samples -> outputs zero immediately; after release, samples without sync are ignored until a sync arrives.

Source files
------------

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: hunts for a sync-marked slot 0, then assembles
// each group of four accepted samples into a registered parallel frame.
module tdm_demux4 #(
   parameter int unsigned W = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   din,
   input  logic           din_valid,
   input  logic           sync,
   output logic [4*W-1:0] Out,
   output logic           out_valid,
   output logic [1:0]     Sel,
   output logic           locked,
   output logic           frame_err
);

   typedef enum logic {StHunt, StLock} state_e;

   state_e               state_q, state_d;
   logic [1:0]           sel_q, sel_d;
   logic [2:0][W-1:0]    shadow_q, shadow_d;
   logic [4*W-1:0]       out_q, out_d;
   logic                 out_valid_q, out_valid_d;
   logic                 frame_err_q, frame_err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StHunt;
         sel_q       <= 2'd0;
         shadow_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         shadow_q    <= shadow_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      shadow_d    = shadow_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      frame_err_d = 1'b0;
      if (din_valid) begin
         unique case (state_q)
            StHunt: begin
               if (sync) begin
                  shadow_d[0] = din;
                  sel_d       = 2'd1;
                  state_d     = StLock;
               end
            end
            StLock: begin
               // A sync mid-frame restarts the frame at this sample; the partial frame is dropped.
               if (sync && (sel_q != 2'd0)) begin
                  frame_err_d = 1'b1;
                  shadow_d[0] = din;
                  sel_d       = 2'd1;
               end else if (sel_q == 2'd3) begin
                  out_d       = {din, shadow_q};
                  out_valid_d = 1'b1;
                  sel_d       = 2'd0;
               end else begin
                  for (int k = 0; k < 3; k++) begin
                     if (sel_q == 2'(k)) shadow_d[k] = din;
                  end
                  sel_d = sel_q + 2'd1;
               end
            end
            default: begin
               state_d = StHunt;
               sel_d   = 2'd0;
            end
         endcase
      end
   end

   assign Out       = out_q;
   assign out_valid = out_valid_q;
   assign Sel       = sel_q;
   assign locked    = (state_q == StLock);
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (W=1): frame table plus scoreboard of
// expected frames, with hand sequences for hunt, resync and async reset.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       sync = 1'b0;
   logic [3:0] out_w;
   logic       out_valid;
   logic [1:0] sel;
   logic       locked;
   logic       frame_err;

   int checks = 0;
   int passes = 0;
   logic [3:0] exp_q[$];

   tdm_demux4 #(.W(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .sync      (sync),
      .Out       (out_w),
      .out_valid (out_valid),
      .Sel       (sel),
      .locked    (locked),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Drive one valid sample; returns 1 time unit after the capturing edge.
   task automatic send(input logic d, input logic s);
      din       = d;
      sync      = s;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      sync      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: every out_valid pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         chk("out_valid_excl_frame_err", {31'd0, frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            chk("frame_out", {28'd0, out_w}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   typedef struct {
      logic [3:0] d;        // bit k is the sample for slot k
      logic [3:0] s;        // sync per sample
      int         gap;      // idle cycles after each sample
      logic [3:0] exp_out;
   } frame_t;

   frame_t tbl[5];

   initial begin
      tbl[0] = '{d: 4'b1101, s: 4'b0001, gap: 0, exp_out: 4'b1101};
      tbl[1] = '{d: 4'b0110, s: 4'b0001, gap: 2, exp_out: 4'b0110};
      tbl[2] = '{d: 4'b0001, s: 4'b0000, gap: 0, exp_out: 4'b0001};
      tbl[3] = '{d: 4'b1010, s: 4'b0001, gap: 1, exp_out: 4'b1010};
      tbl[4] = '{d: 4'b1111, s: 4'b0000, gap: 0, exp_out: 4'b1111};

      // Reset is asynchronous: outputs are zero before any clock edge.
      #1;
      chk("rst_out", {28'd0, out_w}, 32'd0);
      chk("rst_sel", {30'd0, sel}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      idle(2);
      rst = 1'b0;
      idle(3);
      chk("idle_out", {28'd0, out_w}, 32'd0);
      chk("idle_sel", {30'd0, sel}, 32'd0);
      chk("idle_locked", {31'd0, locked}, 32'd0);

      // Pre-lock discard.
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      chk("hunt_sel", {30'd0, sel}, 32'd0);
      chk("hunt_locked", {31'd0, locked}, 32'd0);
      send(1'b0, 1'b1);
      chk("lock_after_sync", {31'd0, locked}, 32'd1);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      exp_q.push_back(4'b1000);
      send(1'b1, 1'b0);
      chk("prelock_frame_out", {28'd0, out_w}, 32'd8);

      // Table of frames, back-to-back or with gaps.
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < 4; k++) begin
            logic [3:0] dv;
            logic [3:0] sv;
            dv = tbl[f].d;
            sv = tbl[f].s;
            if (k == 3) exp_q.push_back(tbl[f].exp_out);
            send(dv[k], sv[k]);
            chk($sformatf("tbl%0d_sel%0d", f, k), {30'd0, sel}, (k + 1) % 4);
            idle(tbl[f].gap);
            if (tbl[f].gap > 0)
               chk($sformatf("tbl%0d_gap_sel%0d", f, k), {30'd0, sel}, (k + 1) % 4);
         end
         chk($sformatf("tbl%0d_locked", f), {31'd0, locked}, 32'd1);
         chk($sformatf("tbl%0d_out_hold", f), {28'd0, out_w}, {28'd0, tbl[f].exp_out});
      end

      // Mid-frame resync at Sel=2.
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      chk("pre_resync_sel", {30'd0, sel}, 32'd2);
      send(1'b0, 1'b1);
      chk("resync_frame_err", {31'd0, frame_err}, 32'd1);
      chk("resync_sel", {30'd0, sel}, 32'd1);
      chk("resync_locked", {31'd0, locked}, 32'd1);
      chk("resync_out_hold", {28'd0, out_w}, 32'hF);
      send(1'b1, 1'b0);
      chk("frame_err_one_cycle", {31'd0, frame_err}, 32'd0);
      send(1'b1, 1'b0);
      exp_q.push_back(4'b1110);
      send(1'b1, 1'b0);
      chk("resync_frame_out", {28'd0, out_w}, 32'hE);

      // Asynchronous reset between edges, mid-frame.
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out", {28'd0, out_w}, 32'd0);
      chk("async_rst_sel", {30'd0, sel}, 32'd0);
      chk("async_rst_locked", {31'd0, locked}, 32'd0);
      idle(1);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) send(1'b1, 1'b0);
      chk("post_rst_hunt_sel", {30'd0, sel}, 32'd0);
      chk("post_rst_hunt_locked", {31'd0, locked}, 32'd0);
      chk("post_rst_out", {28'd0, out_w}, 32'd0);
      send(1'b0, 1'b1);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      exp_q.push_back(4'b1010);
      send(1'b1, 1'b0);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
